srambank_param: RTL and testbench

Parametrised successor to the fixed 256x34 synchronous SRAM bank. It provides NBANK independently selectable banks of DEPTH x WIDTH words, and adds:
- a per-bit write mask
- an optional output pipeline register with a read-valid strobe
- a hardware clear sequencer that initialises every word after reset
- sticky protocol-error flags

It sits behind a cache/queue controller as its storage array. It is behavioural RTL, intended for synthesis mapping to SRAM macros.

---
 rtl/srambank_param.sv | 230 +++++++++++++++++++++++
 tb/tb_srambank_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srambank_param.sv
`default_nettype none
// ============================================================================
//  Module   : srambank_param
//  Purpose  : Parametrised multi-bank synchronous SRAM storage array.
//             NBANK banks of DEPTH x WIDTH words are selected by a one-hot
//             bank select. Features: per-bit write mask, optional output
//             register stage with a read-valid strobe, hardware clear
//             sequencer run after reset, and sticky protocol-error flags.
//
//  Ports    : clk      - clock, all logic on rising edge
//             reset_n  - synchronous reset, active low
//             ADDRESS  - word address within the selected bank
//             wd       - write data
//             wmask    - per-bit write enable (1 = bit written)
//             banksel  - one-hot bank select / access enable
//             read     - read request
//             write    - write request
//             dataout  - registered read data, held until the next read
//             rvalid   - one-cycle pulse when dataout carries new data
//             ready    - clear finished, accesses accepted
//             err      - sticky [0] rd/wr collision, [1] multi-hot banksel,
//                        [2] access while not ready
//
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module srambank_param #(
    parameter int               DEPTH    = 256,
    parameter int               WIDTH    = 34,
    parameter int               NBANK    = 4,
    parameter int               AW       = $clog2(DEPTH),
    parameter int               OUTREG   = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ADDRESS,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] wmask,
    input  logic [NBANK-1:0] banksel,
    input  logic             read,
    input  logic             write,
    output logic [WIDTH-1:0] dataout,
    output logic             rvalid,
    output logic             ready,
    output logic [2:0]       err
);

    // Bank index width; a single bank still needs a one-bit index.
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q,   ptr_d;
    logic [2:0]       err_q,   err_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             rvalid_q,  rvalid_d;

    int               bank_cnt;
    logic [BW-1:0]    bank_idx;
    logic             bank_onehot;
    logic             acc;
    logic             valid_acc;
    logic             do_write;
    logic             do_read;
    logic             clr_we;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] bank_rd [NBANK];

    // ------------------------------------------------------------------
    // Bank select decode: count asserted bits and remember the index of
    // the (last) asserted one. The index is only meaningful when exactly
    // one bit is set, which is the only case in which it is used.
    // ------------------------------------------------------------------
    always_comb begin
        bank_cnt = 0;
        bank_idx = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (banksel[b]) begin
                bank_cnt = bank_cnt + 1;
                bank_idx = BW'(b);
            end
        end
    end

    assign bank_onehot = (bank_cnt == 1);
    assign acc         = (read | write) & (|banksel);
    assign valid_acc   = acc & ready & bank_onehot;
    // A read that coincides with a write is dropped; the write wins.
    assign do_write    = valid_acc & write;
    assign do_read     = valid_acc & read & ~write;
    // The clear sequencer must not advance on the reset edge itself.
    assign clr_we      = (state_q == ST_CLEAR) & reset_n;

    // ------------------------------------------------------------------
    // Clear sequencer / access FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Sticky error flags. A multi-hot select always implies acc has a bank.
    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (valid_acc & read & write);
        err_d[1] = err_q[1] | (acc & ~bank_onehot);
        err_d[2] = err_q[2] | (acc & ~ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // ready is the state bit itself, so it is registered by construction.
    assign ready = (state_q == ST_READY);

    // ------------------------------------------------------------------
    // Storage banks. Contents are never reset; the clear sequencer writes
    // INIT_VAL into every word of every bank in parallel. Clear writes and
    // user writes are mutually exclusive because user writes need ready.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic             we;

        assign we = do_write & (bank_idx == BW'(b));

        always_ff @(posedge clk) begin
            if (clr_we) begin
                mem_q[ptr_q] <= INIT_VAL;
            end else if (we) begin
                mem_q[ADDRESS] <= (mem_q[ADDRESS] & ~wmask) | (wd & wmask);
            end
        end

        assign bank_rd[b] = mem_q[ADDRESS];
    end

    assign rd_word = bank_rd[bank_idx];

    // ------------------------------------------------------------------
    // Output path. Without the extra stage, the read edge loads dataout.
    // With it, the read edge loads a stage register and the following
    // edge moves it to dataout; the stage is fed every cycle so back-to-
    // back reads stream with a fixed latency.
    // ------------------------------------------------------------------
    if (OUTREG == 0) begin : g_outreg_off
        always_comb begin
            dataout_d = dataout_q;
            rvalid_d  = 1'b0;
            if (do_read) begin
                dataout_d = rd_word;
                rvalid_d  = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                dataout_q <= '0;
                rvalid_q  <= 1'b0;
            end else begin
                dataout_q <= dataout_d;
                rvalid_q  <= rvalid_d;
            end
        end
    end else begin : g_outreg_on
        logic [WIDTH-1:0] stage_q, stage_d;
        logic             stage_vld_q, stage_vld_d;

        always_comb begin
            stage_d     = stage_q;
            stage_vld_d = do_read;
            if (do_read) begin
                stage_d = rd_word;
            end
            dataout_d = dataout_q;
            rvalid_d  = stage_vld_q;
            if (stage_vld_q) begin
                dataout_d = stage_q;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                stage_q     <= '0;
                stage_vld_q <= 1'b0;
                dataout_q   <= '0;
                rvalid_q    <= 1'b0;
            end else begin
                stage_q     <= stage_d;
                stage_vld_q <= stage_vld_d;
                dataout_q   <= dataout_d;
                rvalid_q    <= rvalid_d;
            end
        end
    end

    assign dataout = dataout_q;
    assign rvalid  = rvalid_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_srambank_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srambank_param
//  Purpose  : Directed self-checking bench for srambank_param. Two instances
//             share all inputs: u_dut0 without and u_dut1 with the output
//             register stage, so every read checks both latencies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_srambank_param;

    localparam int AW = 8;
    localparam logic [33:0] ONES = {34{1'b1}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] ADDRESS;
    logic [33:0]   wd;
    logic [33:0]   wmask;
    logic [3:0]    banksel;
    logic          read;
    logic          write;

    logic [33:0]   dout0, dout1;
    logic          rv0, rv1;
    logic          rdy0, rdy1;
    logic [2:0]    err0, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    srambank_param #(
        .DEPTH  (256),
        .WIDTH  (34),
        .NBANK  (4),
        .OUTREG (0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .ADDRESS (ADDRESS),
        .wd      (wd),
        .wmask   (wmask),
        .banksel (banksel),
        .read    (read),
        .write   (write),
        .dataout (dout0),
        .rvalid  (rv0),
        .ready   (rdy0),
        .err     (err0)
    );

    srambank_param #(
        .DEPTH  (256),
        .WIDTH  (34),
        .NBANK  (4),
        .OUTREG (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .ADDRESS (ADDRESS),
        .wd      (wd),
        .wmask   (wmask),
        .banksel (banksel),
        .read    (read),
        .write   (write),
        .dataout (dout1),
        .rvalid  (rv1),
        .ready   (rdy1),
        .err     (err1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        banksel = '0;
        ADDRESS = '0;
        read    = 1'b0;
        write   = 1'b0;
        wd      = '0;
        wmask   = '0;
    endtask

    // Present one access for exactly one rising edge, then go idle.
    task automatic access(input logic [3:0] bs, input logic [AW-1:0] a,
                          input logic rd, input logic wr,
                          input logic [33:0] d, input logic [33:0] m);
        banksel = bs;
        ADDRESS = a;
        read    = rd;
        write   = wr;
        wd      = d;
        wmask   = m;
        tick();
        idle();
    endtask

    task automatic wr_word(input logic [3:0] bs, input logic [AW-1:0] a,
                           input logic [33:0] d, input logic [33:0] m);
        access(bs, a, 1'b0, 1'b1, d, m);
    endtask

    // Single read: instance 0 delivers at the request edge, instance 1 one later.
    task automatic rd_check(input string tag, input logic [3:0] bs,
                            input logic [AW-1:0] a, input logic [33:0] exp);
        access(bs, a, 1'b1, 1'b0, '0, '0);
        check_eq({tag, "_data0"}, dout0, exp);
        check_eq({tag, "_rv0"}, rv0, 1);
        check_eq({tag, "_rv1_early"}, rv1, 0);
        tick();
        check_eq({tag, "_data1"}, dout1, exp);
        check_eq({tag, "_rv1"}, rv1, 1);
        check_eq({tag, "_rv0_pulse"}, rv0, 0);
    endtask

    // Count edges until ready, bounded so a stuck DUT cannot hang the run.
    task automatic wait_ready(output int n);
        n = 0;
        while (!rdy0 && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic [33:0] e;
        logic [33:0] exp_b2b [4];

        idle();
        reset_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_dataout0", dout0, 0);
        check_eq("rst_dataout1", dout1, 0);
        check_eq("rst_rvalid0", rv0, 0);
        check_eq("rst_ready0", rdy0, 0);
        check_eq("rst_ready1", rdy1, 0);
        check_eq("rst_err0", err0, 0);

        reset_n = 1'b1;
        wait_ready(n);
        check_eq("clear_edges", n, 256);
        check_eq("clear_ready1", rdy1, 1);
        rd_check("init_b2_ff", 4'b0100, 8'hFF, 34'h0);

        // Reset while the clear pointer sits at 100: clear restarts from 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (100) tick();
        check_eq("midclr_notready", rdy0, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_ready(n);
        check_eq("midclr_edges", n, 256);
        check_eq("midclr_err", err0, 0);

        // Bit-masked write merge.
        wr_word(4'b0001, 8'h10, 34'h3_FFFF_FFFF, ONES);
        wr_word(4'b0001, 8'h10, 34'h0, 34'h0_0000_00FF);
        rd_check("mask_b0", 4'b0001, 8'h10, 34'h3_FFFF_FF00);
        rd_check("mask_b1", 4'b0010, 8'h10, 34'h0);

        // Read immediately after write; then a wmask=0 write must be a no-op.
        wr_word(4'b0001, 8'h20, 34'h1_2345_6789, ONES);
        rd_check("raw", 4'b0001, 8'h20, 34'h1_2345_6789);
        wr_word(4'b0001, 8'h20, 34'h0, 34'h0);
        rd_check("wmask0", 4'b0001, 8'h20, 34'h1_2345_6789);

        // Back-to-back reads in bank 3.
        for (int i = 0; i < 4; i++) begin
            e = 34'h2_0000_00A0 + 34'(i);
            exp_b2b[i] = e;
            wr_word(4'b1000, AW'(i), e, ONES);
        end
        for (int i = 0; i < 4; i++) begin
            banksel = 4'b1000;
            ADDRESS = AW'(i);
            read    = 1'b1;
            tick();
            check_eq($sformatf("b2b%0d_data0", i), dout0, exp_b2b[i]);
            check_eq($sformatf("b2b%0d_rv0", i), rv0, 1);
            if (i > 0) begin
                check_eq($sformatf("b2b%0d_data1", i), dout1, exp_b2b[i-1]);
                check_eq($sformatf("b2b%0d_rv1", i), rv1, 1);
            end else begin
                check_eq("b2b0_rv1", rv1, 0);
            end
        end
        idle();
        tick();
        check_eq("b2b_tail_data1", dout1, exp_b2b[3]);
        check_eq("b2b_tail_rv1", rv1, 1);
        check_eq("b2b_tail_rv0", rv0, 0);
        check_eq("b2b_tail_hold0", dout0, exp_b2b[3]);

        // Read and write together: write wins, no read, collision flag.
        access(4'b0001, 8'h05, 1'b1, 1'b1, 34'h2A, ONES);
        check_eq("coll_rv0", rv0, 0);
        check_eq("coll_hold0", dout0, 34'h2_0000_00A3);
        check_eq("coll_err0", err0, 3'b001);
        tick();
        check_eq("coll_rv1", rv1, 0);
        check_eq("coll_hold1", dout1, 34'h2_0000_00A3);
        check_eq("coll_err1", err1, 3'b001);
        rd_check("coll_mem", 4'b0001, 8'h05, 34'h2A);
        check_eq("coll_sticky", err0, 3'b001);

        // Multi-hot select: nothing written anywhere.
        wr_word(4'b0011, 8'h30, 34'h3_0000_0001, ONES);
        check_eq("multi_err", err0, 3'b011);
        rd_check("multi_b0", 4'b0001, 8'h30, 34'h0);
        rd_check("multi_b1", 4'b0010, 8'h30, 34'h0);

        // Accesses during clear are ignored and flagged.
        reset_n = 1'b0;
        tick();
        check_eq("rst2_err", err0, 0);
        check_eq("rst2_dataout0", dout0, 0);
        check_eq("rst2_dataout1", dout1, 0);
        reset_n = 1'b1;
        repeat (50) tick();
        access(4'b0001, 8'h00, 1'b0, 1'b1, 34'h1_5555_5555, ONES);
        check_eq("clr_acc_err", err0, 3'b100);
        access(4'b0001, 8'h00, 1'b1, 1'b0, '0, '0);
        check_eq("clr_rd_rv0", rv0, 0);
        wait_ready(n);
        check_eq("clr_acc_ready", rdy0, 1);
        rd_check("clr_ignored", 4'b0001, 8'h00, 34'h0);
        check_eq("clr_err0_final", err0, 3'b100);
        check_eq("clr_err1_final", err1, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
